// File: rtl/pc_trace_buffer.sv
// Instruction-trace capture: records every fetched PC into a circular buffer and
// freezes the history on halt, on a PC breakpoint (after a post-trigger window) or when full in one-shot mode.
module pc_trace_buffer #(
   parameter int PC_W     = 9,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int POST_CNT = 4
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              fetch_valid,
   input  logic [PC_W-1:0]   fetch_pc,
   input  logic              halt,
   input  logic              mode,
   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_pc,
   input  logic              arm,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_idx,
   output logic [PC_W-1:0]   rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   output logic [ADDR_W:0]   count,
   output logic              wrapped,
   output logic              bp_hit,
   output logic              frozen
);

   typedef enum logic [1:0] {CAPTURE, POST, FROZEN} state_t;

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W-1:0] POST_LD  = ADDR_W'(POST_CNT);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] post_cnt;
   logic [PC_W-1:0]   mem [DEPTH];

   logic              capture;
   logic              full;
   logic              bp_match;
   logic              oneshot_stop;
   logic [ADDR_W-1:0] rd_addr;

   // arm drops any fetch in the same cycle; FROZEN ignores fetches entirely.
   assign capture      = fetch_valid && (state != FROZEN) && !arm;
   assign full         = (count == FULL_CNT);
   assign bp_match     = (state == CAPTURE) && bp_en && capture && (fetch_pc == bp_pc);
   assign oneshot_stop = mode && capture && (count >= LAST_CNT);
   // Index 0 is the oldest entry: once full, that is the slot about to be overwritten.
   assign rd_addr      = (full ? wr_ptr : '0) + rd_idx;
   assign frozen       = (state == FROZEN);

   always_ff @(posedge CLOCK_50) begin
      if (capture) mem[wr_ptr] <= fetch_pc;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= CAPTURE;
         wr_ptr   <= '0;
         post_cnt <= '0;
         count    <= '0;
         wrapped  <= 1'b0;
         bp_hit   <= 1'b0;
      end else if (arm) begin
         state    <= CAPTURE;
         wr_ptr   <= '0;
         post_cnt <= '0;
         count    <= '0;
         wrapped  <= 1'b0;
         bp_hit   <= 1'b0;
      end else begin
         if (capture) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full) count   <= count + 1'b1;
            else       wrapped <= 1'b1;
         end
         case (state)
            CAPTURE: begin
               if (bp_match) bp_hit <= 1'b1;
               if (halt || oneshot_stop || (bp_match && POST_CNT == 0)) begin
                  state <= FROZEN;
               end else if (bp_match) begin
                  state    <= POST;
                  post_cnt <= POST_LD;
               end
            end
            POST: begin
               if (capture) post_cnt <= post_cnt - 1'b1;
               if (halt || oneshot_stop || (capture && post_cnt == ADDR_W'(1))) state <= FROZEN;
            end
            default: state <= FROZEN;
         endcase
      end
   end

   // Read port: rd_en is a request with no back-pressure; rd_valid pulses exactly
   // one cycle later carrying rd_data/rd_err, and rd_data holds when rd_valid is low.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else if (rd_en) begin
         rd_valid <= 1'b1;
         if ({1'b0, rd_idx} >= count) begin
            rd_data <= '0;
            rd_err  <= 1'b1;
         end else begin
            rd_data <= mem[rd_addr];
            rd_err  <= 1'b0;
         end
      end else begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: a vector table for basic capture/readout plus
// hand sequences for one-shot, breakpoint, halt/arm and asynchronous reset.
module tb_pc_trace_buffer;

   localparam int PC_W = 9;
   localparam int DEPTH = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_n, fetch_valid, halt, mode, bp_en, arm, rd_en;
   logic [PC_W-1:0] fetch_pc, bp_pc;
   logic [AW-1:0]   rd_idx;

   logic [PC_W-1:0] rd_data, d0_rd_data;
   logic            rd_valid, rd_err, wrapped, bp_hit, frozen;
   logic            d0_rd_valid, d0_rd_err, d0_wrapped, d0_bp_hit, d0_frozen;
   logic [AW:0]     count, d0_count;

   pc_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .POST_CNT(2)) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .halt(halt), .mode(mode), .bp_en(bp_en), .bp_pc(bp_pc), .arm(arm),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_err(rd_err), .count(count), .wrapped(wrapped), .bp_hit(bp_hit), .frozen(frozen)
   );

   pc_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .POST_CNT(0)) dut0 (
      .CLOCK_50(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .halt(halt), .mode(mode), .bp_en(bp_en), .bp_pc(bp_pc), .arm(arm),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(d0_rd_data), .rd_valid(d0_rd_valid),
      .rd_err(d0_rd_err), .count(d0_count), .wrapped(d0_wrapped), .bp_hit(d0_bp_hit),
      .frozen(d0_frozen)
   );

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic            fv;
      logic [PC_W-1:0] pc;
      logic            arm;
      logic            rd_en;
      logic [AW-1:0]   idx;
      logic [AW:0]     e_count;
      logic            e_wrapped;
      logic            e_rdv;
      logic [PC_W-1:0] e_rdata;
      logic            e_rderr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [PC_W-1:0] pc);
      fetch_valid = 1'b1;
      fetch_pc = pc;
      tick();
      fetch_valid = 1'b0;
   endtask

   task automatic arm_pulse(input logic with_fetch);
      arm = 1'b1;
      fetch_valid = with_fetch;
      fetch_pc = 9'h1ff;
      tick();
      arm = 1'b0;
      fetch_valid = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [AW-1:0] idx,
                           input logic [PC_W-1:0] exp_d, input logic exp_e);
      rd_en = 1'b1;
      rd_idx = idx;
      tick();
      rd_en = 1'b0;
      check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
      check({tag, " rd_err"}, 32'(rd_err), 32'(exp_e));
      check({tag, " rd_data"}, 32'(rd_data), 32'(exp_d));
   endtask

   task automatic read_pair(input string tag, input logic [AW-1:0] idx,
                            input logic [PC_W-1:0] exp_d, input logic exp_e,
                            input logic [PC_W-1:0] exp_d0, input logic exp_e0);
      read_chk(tag, idx, exp_d, exp_e);
      check({tag, " d0 rd_valid"}, 32'(d0_rd_valid), 32'd1);
      check({tag, " d0 rd_err"}, 32'(d0_rd_err), 32'(exp_e0));
      check({tag, " d0 rd_data"}, 32'(d0_rd_data), 32'(exp_d0));
   endtask

   function automatic void add(input logic fv, input logic [PC_W-1:0] pc, input logic a,
                               input logic re, input logic [AW-1:0] idx, input logic [AW:0] ec,
                               input logic ew, input logic erv, input logic [PC_W-1:0] erd,
                               input logic ere);
      vecs.push_back('{fv, pc, a, re, idx, ec, ew, erv, erd, ere});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; halt = 1'b0; mode = 1'b0;
      bp_en = 1'b0; bp_pc = '0; arm = 1'b0; rd_en = 1'b0; rd_idx = '0;

      // fetch 0..4, read them back, out-of-range read, idle, arm
      for (int i = 0; i < 5; i++) add(1'b1, 9'(i), 0, 0, 0, 4'(i + 1), 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(1'b0, 0, 0, 1, 3'(i), 4'd5, 0, 1, 9'(i), 0);
      add(0, 0, 0, 1, 3'd5, 4'd5, 0, 1, 9'h0, 1);
      add(0, 0, 0, 0, 0, 4'd5, 0, 0, 9'h0, 0);
      add(0, 0, 1, 0, 0, 4'd0, 0, 0, 9'h0, 0);
      // circular wrap with 10 fetches, then readout including read-during-write
      for (int i = 0; i < 10; i++)
         add(1'b1, 9'(16 + i), 0, 0, 0, (i < 8) ? 4'(i + 1) : 4'd8, (i >= 8), 0, 0, 0);
      add(0, 0, 0, 1, 3'd0, 4'd8, 1, 1, 9'h012, 0);
      add(0, 0, 0, 1, 3'd3, 4'd8, 1, 1, 9'h015, 0);
      add(0, 0, 0, 1, 3'd7, 4'd8, 1, 1, 9'h019, 0);
      add(1, 9'h01a, 0, 1, 3'd0, 4'd8, 1, 1, 9'h012, 0);
      add(0, 0, 0, 1, 3'd0, 4'd8, 1, 1, 9'h013, 0);
      add(0, 0, 0, 1, 3'd7, 4'd8, 1, 1, 9'h01a, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset count", 32'(count), 0);
      check("reset frozen", 32'(frozen), 0);
      check("reset wrapped", 32'(wrapped), 0);
      check("reset bp_hit", 32'(bp_hit), 0);
      check("reset rd_valid", 32'(rd_valid), 0);
      check("reset rd_err", 32'(rd_err), 0);
      check("reset rd_data", 32'(rd_data), 0);
      reset_n = 1'b1;

      foreach (vecs[k]) begin
         fetch_valid = vecs[k].fv;
         fetch_pc = vecs[k].pc;
         arm = vecs[k].arm;
         rd_en = vecs[k].rd_en;
         rd_idx = vecs[k].idx;
         tick();
         fetch_valid = 1'b0; arm = 1'b0; rd_en = 1'b0;
         check($sformatf("v%0d count", k), 32'(count), 32'(vecs[k].e_count));
         check($sformatf("v%0d wrapped", k), 32'(wrapped), 32'(vecs[k].e_wrapped));
         check($sformatf("v%0d frozen", k), 32'(frozen), 0);
         check($sformatf("v%0d rd_valid", k), 32'(rd_valid), 32'(vecs[k].e_rdv));
         check($sformatf("v%0d rd_err", k), 32'(rd_err), 32'(vecs[k].e_rderr));
         if (vecs[k].e_rdv) check($sformatf("v%0d rd_data", k), 32'(rd_data), 32'(vecs[k].e_rdata));
      end

      // one-shot: freezes on the 8th fetch, later fetches ignored
      mode = 1'b1;
      arm_pulse(1'b0);
      for (int i = 0; i < 8; i++) begin
         fetch(9'(16 + i));
         check($sformatf("oneshot frozen %0d", i), 32'(frozen), 32'(i == 7));
      end
      fetch(9'h018);
      fetch(9'h019);
      check("oneshot count", 32'(count), 8);
      check("oneshot frozen", 32'(frozen), 1);
      check("oneshot wrapped", 32'(wrapped), 0);
      read_chk("oneshot idx7", 3'd7, 9'h017, 1'b0);
      read_chk("oneshot idx0", 3'd0, 9'h010, 1'b0);
      mode = 1'b0;

      // breakpoint at 0x005: POST_CNT=2 on dut, POST_CNT=0 on dut0
      bp_en = 1'b1;
      bp_pc = 9'h005;
      arm_pulse(1'b0);
      for (int i = 0; i < 10; i++) begin
         fetch(9'(i));
         check($sformatf("bp frozen %0d", i), 32'(frozen), 32'(i >= 7));
         check($sformatf("bp count %0d", i), 32'(count), (i < 8) ? i + 1 : 8);
         check($sformatf("bp bp_hit %0d", i), 32'(bp_hit), 32'(i >= 5));
         check($sformatf("bp0 frozen %0d", i), 32'(d0_frozen), 32'(i >= 5));
         check($sformatf("bp0 count %0d", i), 32'(d0_count), (i < 6) ? i + 1 : 6);
      end
      check("bp wrapped", 32'(wrapped), 0);
      check("bp0 bp_hit", 32'(d0_bp_hit), 1);
      read_pair("bp idx5", 3'd5, 9'h005, 1'b0, 9'h005, 1'b0);
      read_pair("bp idx6", 3'd6, 9'h006, 1'b0, 9'h000, 1'b1);
      read_pair("bp idx7", 3'd7, 9'h007, 1'b0, 9'h000, 1'b1);
      read_pair("bp idx0", 3'd0, 9'h000, 1'b0, 9'h000, 1'b0);
      bp_en = 1'b0;
      arm_pulse(1'b1);
      check("bp arm count", 32'(count), 0);
      check("bp arm frozen", 32'(frozen), 0);
      check("bp arm bp_hit", 32'(bp_hit), 0);
      check("bp0 arm bp_hit", 32'(d0_bp_hit), 0);
      read_chk("bp arm drop", 3'd0, 9'h000, 1'b1);

      // halt with a simultaneous fetch, then arm with a simultaneous fetch
      arm_pulse(1'b0);
      fetch(9'h030);
      fetch(9'h031);
      fetch(9'h032);
      halt = 1'b1;
      fetch(9'h033);
      halt = 1'b0;
      check("halt count", 32'(count), 4);
      check("halt frozen", 32'(frozen), 1);
      fetch(9'h034);
      check("halt ignore count", 32'(count), 4);
      read_chk("halt idx3", 3'd3, 9'h033, 1'b0);
      read_chk("halt idx4", 3'd4, 9'h000, 1'b1);
      arm_pulse(1'b1);
      check("halt arm count", 32'(count), 0);
      check("halt arm frozen", 32'(frozen), 0);

      // asynchronous reset between edges
      arm_pulse(1'b0);
      for (int i = 0; i < 9; i++) fetch(9'(80 + i));
      halt = 1'b1; rd_en = 1'b1; rd_idx = 3'd0;
      tick();
      halt = 1'b0; rd_en = 1'b0;
      check("pre-rst frozen", 32'(frozen), 1);
      check("pre-rst wrapped", 32'(wrapped), 1);
      check("pre-rst rd_valid", 32'(rd_valid), 1);
      check("pre-rst count", 32'(count), 8);
      #3 reset_n = 1'b0;
      #1;
      check("async count", 32'(count), 0);
      check("async frozen", 32'(frozen), 0);
      check("async rd_valid", 32'(rd_valid), 0);
      check("async wrapped", 32'(wrapped), 0);
      #1 reset_n = 1'b1;
      fetch(9'h040);
      check("post-rst count", 32'(count), 1);
      read_chk("post-rst idx0", 3'd0, 9'h040, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
